// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the CPU datapath: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath selects, and guards DM accesses with a timeout.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       alu_flag,
  input  logic       mem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] reg_src,
  output logic       alu_src,
  output logic [4:0] alu_ctrl,
  output logic [2:0] ext_ctrl,
  output logic [2:0] npc_ctrl,
  output logic [2:0] dm_ctrl,
  output logic       mem_req,
  output logic       mem_write,
  output logic       retire,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_o
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;
  localparam logic [4:0] ALU_LUI = 5'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB       = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

  // Next state and per-state controls; everything held at zero while reset is high.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    cnt_d      = cnt_q;
    dec_bad    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    reg_src    = 2'b00;
    alu_src    = 1'b0;
    alu_ctrl   = ALU_ADD;
    ext_ctrl   = 3'd0;
    npc_ctrl   = 3'd0;
    dm_ctrl    = 3'd0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    retire     = 1'b0;
    illegal_op = 1'b0;
    bus_error  = 1'b0;

    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          op_d    = op;
          funct_d = funct;
          case (op)
            OP_RTYPE: begin
              if (funct == FN_ADDU || funct == FN_SUBU) state_d = S_EXEC_R;
              else if (funct == FN_JR)                  state_d = S_JUMP;
              else                                      dec_bad = 1'b1;
            end
            OP_ORI, OP_LUI: state_d = S_EXEC_I;
            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
            OP_BEQ:         state_d = S_BRANCH;
            OP_J, OP_JAL:   state_d = S_JUMP;
            default:        dec_bad = 1'b1;
          endcase
          // Unsupported encodings skip to the next sequential instruction.
          if (dec_bad) begin
            illegal_op = 1'b1;
            pc_we      = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_EXEC_R: begin
          alu_ctrl = (funct_q == FN_SUBU) ? ALU_SUB : ALU_ADD;
          state_d  = S_WB;
        end
        S_EXEC_I: begin
          alu_src  = 1'b1;
          alu_ctrl = (op_q == OP_LUI) ? ALU_LUI : ALU_OR;
          state_d  = S_WB;
        end
        S_MEM_ADDR: begin
          alu_src  = 1'b1;
          ext_ctrl = 3'd1;
          cnt_d    = '0;
          state_d  = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD, S_MEM_WR: begin
          mem_req  = 1'b1;
          alu_src  = 1'b1;
          ext_ctrl = 3'd1;
          if (mem_ready) begin
            if (state_q == S_MEM_WR) begin
              mem_write = 1'b1;
              pc_we     = 1'b1;
              retire    = 1'b1;
              state_d   = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (cnt_q == CNT_LAST) begin
            bus_error = 1'b1;
            pc_we     = 1'b1;
            state_d   = S_FETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_we     = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
          if (op_q == OP_LW)         reg_src = 2'b01;
          else if (op_q == OP_RTYPE) reg_dst = 2'b01;
        end
        S_BRANCH: begin
          alu_ctrl = ALU_SUB;
          ext_ctrl = 3'd1;
          npc_ctrl = alu_flag ? 3'd1 : 3'd0;
          pc_we    = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_JUMP: begin
          pc_we    = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
          npc_ctrl = (op_q == OP_RTYPE) ? 3'd3 : 3'd2;
          if (op_q == OP_JAL) begin
            reg_write = 1'b1;
            reg_dst   = 2'b10;
            reg_src   = 2'b10;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: a per-instruction cycle model predicts every control
// output each cycle, including memory waits, timeouts and mid-instruction resets.
module tb_mc_ctrl_fsm;

  localparam int T = 16;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic       alu_src;
    logic [4:0] alu_ctrl;
    logic [2:0] ext_ctrl;
    logic [2:0] npc_ctrl;
    logic [2:0] dm_ctrl;
    logic       mem_req;
    logic       mem_write;
    logic       retire;
    logic       illegal_op;
    logic       bus_error;
    logic [3:0] state;
  } ctl_t;

  typedef struct packed {
    ctl_t e;
    logic rdy;
    logic flag;
    logic dec;
  } cyc_t;

  localparam int CW = $bits(ctl_t);

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       alu_flag, mem_ready;
  logic       ir_we, pc_we, reg_write, alu_src, mem_req, mem_write, retire, illegal_op, bus_error;
  logic [1:0] reg_dst, reg_src;
  logic [4:0] alu_ctrl;
  logic [2:0] ext_ctrl, npc_ctrl, dm_ctrl;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  cyc_t cq[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .alu_flag(alu_flag),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .reg_write(reg_write),
    .reg_dst(reg_dst), .reg_src(reg_src), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .ext_ctrl(ext_ctrl), .npc_ctrl(npc_ctrl), .dm_ctrl(dm_ctrl), .mem_req(mem_req),
    .mem_write(mem_write), .retire(retire), .illegal_op(illegal_op),
    .bus_error(bus_error), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic ctl_t blank(input logic [3:0] s);
    ctl_t e;
    e = '0;
    e.state = s;
    return e;
  endfunction

  function automatic ctl_t sample();
    ctl_t g;
    g.ir_we = ir_we;         g.pc_we = pc_we;         g.reg_write = reg_write;
    g.reg_dst = reg_dst;     g.reg_src = reg_src;     g.alu_src = alu_src;
    g.alu_ctrl = alu_ctrl;   g.ext_ctrl = ext_ctrl;   g.npc_ctrl = npc_ctrl;
    g.dm_ctrl = dm_ctrl;     g.mem_req = mem_req;     g.mem_write = mem_write;
    g.retire = retire;       g.illegal_op = illegal_op; g.bus_error = bus_error;
    g.state = state_o;
    return g;
  endfunction

  task automatic add(input ctl_t e, input logic rdy, input logic flag, input logic dec);
    cyc_t c;
    c.e = e; c.rdy = rdy; c.flag = flag; c.dec = dec;
    cq.push_back(c);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction; w = cycles before mem_ready.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input int w, input logic flag);
    ctl_t e;
    bit r_alu, i_alu, mem, jr, jmp, sw;
    r_alu = (o == 6'h00) && (f == 6'h21 || f == 6'h23);
    jr    = (o == 6'h00) && (f == 6'h08);
    i_alu = (o == 6'h0D) || (o == 6'h0F);
    mem   = (o == 6'h23) || (o == 6'h2B);
    jmp   = jr || o == 6'h02 || o == 6'h03;
    sw    = (o == 6'h2B);
    cq.delete();
    e = blank(4'd0); e.ir_we = 1'b1;
    add(e, rnd(), rnd(), 1'b0);
    e = blank(4'd1);
    if (!(r_alu || i_alu || mem || jmp || o == 6'h04)) begin
      e.illegal_op = 1'b1; e.pc_we = 1'b1;
      add(e, rnd(), rnd(), 1'b1);
      return;
    end
    add(e, rnd(), rnd(), 1'b1);
    if (r_alu || i_alu) begin
      e = blank(r_alu ? 4'd2 : 4'd3);
      e.alu_src  = i_alu;
      e.alu_ctrl = r_alu ? ((f == 6'h23) ? 5'd1 : 5'd0) : ((o == 6'h0F) ? 5'd3 : 5'd2);
      add(e, rnd(), rnd(), 1'b0);
      e = blank(4'd7);
      e.reg_write = 1'b1; e.reg_dst = r_alu ? 2'b01 : 2'b00;
      e.pc_we = 1'b1; e.retire = 1'b1;
      add(e, rnd(), rnd(), 1'b0);
    end else if (o == 6'h04) begin
      e = blank(4'd8);
      e.alu_ctrl = 5'd1; e.ext_ctrl = 3'd1; e.npc_ctrl = flag ? 3'd1 : 3'd0;
      e.pc_we = 1'b1; e.retire = 1'b1;
      add(e, rnd(), flag, 1'b0);
    end else if (jmp) begin
      e = blank(4'd9);
      e.npc_ctrl = jr ? 3'd3 : 3'd2;
      if (o == 6'h03) begin
        e.reg_write = 1'b1; e.reg_dst = 2'b10; e.reg_src = 2'b10;
      end
      e.pc_we = 1'b1; e.retire = 1'b1;
      add(e, rnd(), rnd(), 1'b0);
    end else begin
      e = blank(4'd4); e.alu_src = 1'b1; e.ext_ctrl = 3'd1;
      add(e, rnd(), rnd(), 1'b0);
      for (int k = 0; k < T; k++) begin
        e = blank(sw ? 4'd6 : 4'd5);
        e.mem_req = 1'b1; e.alu_src = 1'b1; e.ext_ctrl = 3'd1;
        if (k == w) begin
          if (sw) begin
            e.mem_write = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
          end
          add(e, 1'b1, rnd(), 1'b0);
          if (!sw) begin
            e = blank(4'd7);
            e.reg_write = 1'b1; e.reg_src = 2'b01; e.pc_we = 1'b1; e.retire = 1'b1;
            add(e, rnd(), rnd(), 1'b0);
          end
          break;
        end
        if (k == T - 1) begin
          e.bus_error = 1'b1; e.pc_we = 1'b1;
        end
        add(e, 1'b0, rnd(), 1'b0);
      end
    end
  endtask

  // Drives one instruction; rst_at >= 0 pulses reset in that cycle and abandons the rest.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int w,
                           input logic flag, input int rst_at, input string name);
    ctl_t exp_c;
    build(o, f, w, flag);
    for (int k = 0; k < cq.size(); k++) begin
      @(negedge clk);
      reset     = (k == rst_at);
      op        = cq[k].dec ? o : 6'($urandom);
      funct     = cq[k].dec ? f : 6'($urandom);
      mem_ready = cq[k].rdy;
      alu_flag  = cq[k].flag;
      exp_c     = (k == rst_at) ? blank(cq[k].e.state) : cq[k].e;
      #1;
      check($sformatf("%s op=%h fn=%h c%0d", name, o, f, k), sample(), exp_c);
      if (k == rst_at) break;
    end
  endtask

  logic [5:0] ops[11] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F};
  logic [5:0] fns[3]  = '{6'h21, 6'h23, 6'h08};

  initial begin
    logic [5:0] o, f;
    int w, ra;
    reset = 1'b1; op = '0; funct = '0; alu_flag = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = rnd(); alu_flag = rnd();
      #1;
      check($sformatf("reset c%0d", i), sample(), blank(4'd0));
    end

    run_instr(6'h00, 6'h21, 0, 1'b0, -1, "addu");
    run_instr(6'h23, 6'h00, 2, 1'b0, -1, "lw_w2");
    run_instr(6'h2B, 6'h00, T + 3, 1'b0, -1, "sw_timeout");
    run_instr(6'h04, 6'h00, 0, 1'b1, -1, "beq_taken");
    run_instr(6'h04, 6'h00, 0, 1'b0, -1, "beq_not");
    run_instr(6'h03, 6'h11, 0, 1'b0, -1, "jal");
    run_instr(6'h02, 6'h00, 0, 1'b0, -1, "j");
    run_instr(6'h00, 6'h08, 0, 1'b0, -1, "jr");
    run_instr(6'h00, 6'h23, 0, 1'b0, -1, "subu");
    run_instr(6'h0D, 6'h00, 0, 1'b0, -1, "ori");
    run_instr(6'h0F, 6'h00, 0, 1'b0, -1, "lui");
    run_instr(6'h3F, 6'h00, 0, 1'b0, -1, "illegal_op");
    run_instr(6'h00, 6'h00, 0, 1'b0, -1, "illegal_fn");
    run_instr(6'h2B, 6'h00, 0, 1'b0, -1, "sw_w0");
    run_instr(6'h23, 6'h00, T - 1, 1'b0, -1, "lw_lastcyc");
    run_instr(6'h23, 6'h00, T, 1'b0, -1, "lw_timeout");
    run_instr(6'h23, 6'h00, 0, 1'b0, 3, "lw_rst_memrd");
    run_instr(6'h00, 6'h21, 0, 1'b0, -1, "after_rst");

    for (int n = 0; n < 300; n++) begin
      o = ops[$urandom_range(10, 0)];
      if (o == 6'h3F) o = 6'($urandom);
      f = 6'($urandom);
      if (o == 6'h00 && $urandom_range(3, 0) != 0) f = fns[$urandom_range(2, 0)];
      w  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(T + 2, T - 2)) : int'($urandom_range(4, 0));
      ra = ($urandom_range(15, 0) == 0) ? int'($urandom_range(6, 0)) : -1;
      run_instr(o, f, w, rnd(), ra, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
